input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 112 +++++++++++
 tb/tb_input_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Input conditioner for two active-low KEY pins and ten active-high SW pins.
// Each raw bit is synchronized, then debounced by a per-bit stable register
// and saturating counter; key press/release events come from stable edges.
// Optional feature macro: INPUT_CONDITIONER_EVENT_LATCH_EN makes key events
// sticky until cleared by evt_clear; when undefined, events are 1-cycle pulses.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] key_in,
   input  logic [9:0] sw_in,
   input  logic [1:0] evt_clear,
   output logic [1:0] key_out,
   output logic [9:0] sw_out,
   output logic [1:0] key_press,
   output logic [1:0] key_release
);

   localparam int              NB      = 12;
   localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   // Bits [1:0] are keys (idle high), bits [11:2] are switches (idle low).
   localparam logic [NB-1:0]   IDLE    = {10'h000, 2'b11};

   logic [NB-1:0] raw;
   logic [NB-1:0] sync1;
   logic [NB-1:0] sync2;
   logic [NB-1:0] stable;
   logic [NB-1:0] load;
   logic [CW-1:0] cnt [NB];
   logic [1:0]    press_set;
   logic [1:0]    release_set;

   assign raw = {sw_in, key_in};

   // Two-flop synchronizer bringing every raw pin into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so sync2 sees the old sync1.
      if (!reset_n) begin
         sync1 <= IDLE;
         sync2 <= IDLE;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // A bit is accepted once it has differed from stable for DEBOUNCE_CYCLES cycles.
   always_comb begin
      // NOTE: default first so no path leaves load unassigned (prevents a latch).
      load = '0;
      for (int i = 0; i < NB; i++) begin
         load[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      end
   end

   // Per-bit debounce counters and stable registers; counters saturate via load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= IDLE;
         // NOTE: the counter array is ordinary flops, so it is reset like any other state.
         for (int i = 0; i < NB; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (load[i]) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // A key press is a stable 1->0 accept, a release is a stable 0->1 accept.
   assign press_set   = load[1:0] &  stable[1:0];
   assign release_set = load[1:0] & ~stable[1:0];

`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
   // Sticky events: set on the accept edge, cleared after evt_clear; set wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_press   <= 2'b00;
         key_release <= 2'b00;
      end else begin
         key_press   <= press_set   | (key_press   & ~evt_clear);
         key_release <= release_set | (key_release & ~evt_clear);
      end
   end
`else
   logic evt_clear_unused;
   assign evt_clear_unused = ^evt_clear;

   // Pulse events: high for the single cycle following the accept edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_press   <= 2'b00;
         key_release <= 2'b00;
      end else begin
         key_press   <= press_set;
         key_release <= release_set;
      end
   end
`endif

   assign key_out = stable[1:0];
   assign sw_out  = stable[NB-1:2];

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Expected per-cycle outputs are queued when stimulus is applied and
// popped and compared on the falling edge as the DUT produces them.
module tb_input_conditioner;

   localparam int N   = 4;
   localparam int LAT = 2 + N;
`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] ko;
      logic [9:0] so;
      logic [1:0] kp;
      logic [1:0] kr;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic [1:0] key_in;
   logic [9:0] sw_in;
   logic [1:0] evt_clear;
   logic [1:0] key_out;
   logic [9:0] sw_out;
   logic [1:0] key_press;
   logic [1:0] key_release;

   exp_t        sb[$];
   exp_t        e;
   logic [15:0] obs;
   int          total = 0;
   int          bad   = 0;

   input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_in      (key_in),
      .sw_in       (sw_in),
      .evt_clear   (evt_clear),
      .key_out     (key_out),
      .sw_out      (sw_out),
      .key_press   (key_press),
      .key_release (key_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(logic [1:0] ko, logic [9:0] so, logic [1:0] kp, logic [1:0] kr);
      return {ko, so, kp, kr};
   endfunction

   // Event visibility k samples after a clean raw change.
   function automatic logic evt(int k);
      return (k == LAT) || (LATCH && k > LAT);
   endfunction

   // Return inputs to idle, let everything settle and clear any sticky events.
   task automatic settle_idle();
      key_in = 2'b11;
      sw_in  = 10'h000;
      repeat (LAT + 3) @(negedge clk);
      evt_clear = 2'b11;
      @(negedge clk);
      evt_clear = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      key_in    = 2'b00;
      sw_in     = 10'h3FF;
      evt_clear = 2'b00;
      for (int k = 1; k <= 3; k++) sb.push_back(mk(2'b11, 10'h000, 2'b00, 2'b00));
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL reset_hold s%0d got=%h exp=%h", k, obs, e); end
      end
      reset_n = 1'b1;
      for (int k = 1; k <= LAT + 2; k++)
         sb.push_back(mk(k >= LAT ? 2'b00 : 2'b11, k >= LAT ? 10'h3FF : 10'h000,
                         evt(k) ? 2'b11 : 2'b00, 2'b00));
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL reset_release s%0d got=%h exp=%h", k, obs, e); end
      end
      settle_idle();
   endtask

   task automatic test_glitch();
      key_in[0] = 1'b0;
      for (int k = 1; k <= 12; k++) sb.push_back(mk(2'b11, 10'h000, 2'b00, 2'b00));
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL glitch s%0d got=%h exp=%h", k, obs, e); end
         if (k == 3) key_in[0] = 1'b1;
      end
   endtask

   task automatic test_press();
      key_in[0] = 1'b0;
      for (int k = 1; k <= LAT + 4; k++)
         sb.push_back(mk({1'b1, k >= LAT ? 1'b0 : 1'b1}, 10'h000,
                         {1'b0, evt(k) && k <= LAT + 3}, 2'b00));
      for (int k = 1; k <= LAT + 4; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL press s%0d got=%h exp=%h", k, obs, e); end
         if (k == LAT + 3) evt_clear = 2'b01;
         if (k == LAT + 4) evt_clear = 2'b00;
      end
      key_in[0] = 1'b1;
      for (int k = 1; k <= LAT + 2; k++)
         sb.push_back(mk({1'b1, k >= LAT ? 1'b1 : 1'b0}, 10'h000, 2'b00, {1'b0, evt(k)}));
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL release s%0d got=%h exp=%h", k, obs, e); end
      end
      settle_idle();
   endtask

   task automatic test_simultaneous();
      key_in[1] = 1'b0;
      for (int k = 1; k <= LAT + 2; k++)
         sb.push_back(mk({k >= LAT ? 1'b0 : 1'b1, 1'b1}, 10'h000, {evt(k), 1'b0}, 2'b00));
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL simul_press s%0d got=%h exp=%h", k, obs, e); end
      end
      evt_clear = 2'b10;
      @(negedge clk);
      evt_clear = 2'b00;
      key_in[1] = 1'b1;
      for (int k = 1; k <= LAT + 3; k++)
         sb.push_back(mk({k >= LAT ? 1'b1 : 1'b0, 1'b1}, 10'h000, 2'b00,
                         {(k == LAT) || (LATCH && k == LAT + 1), 1'b0}));
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL simul_release s%0d got=%h exp=%h", k, obs, e); end
         if (k == LAT - 1) evt_clear = 2'b10;
         if (k == LAT)     evt_clear = 2'b00;
         if (k == LAT + 1) evt_clear = 2'b10;
         if (k == LAT + 2) evt_clear = 2'b00;
      end
      settle_idle();
   endtask

   task automatic test_switches();
      sw_in = 10'h2A5;
      for (int k = 1; k <= LAT + 2; k++)
         sb.push_back(mk(2'b11, k >= LAT ? 10'h2A5 : 10'h000, 2'b00, 2'b00));
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL switches s%0d got=%h exp=%h", k, obs, e); end
      end
      settle_idle();
   endtask

   task automatic test_reset_mid();
      sw_in = 10'h2A5;
      repeat (LAT + 2) @(negedge clk);
      key_in[0] = 1'b0;
      for (int k = 1; k <= 2; k++) sb.push_back(mk(2'b11, 10'h2A5, 2'b00, 2'b00));
      sb.push_back(mk(2'b11, 10'h000, 2'b00, 2'b00));
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL reset_mid s%0d got=%h exp=%h", k, obs, e); end
         if (k == 2) reset_n = 1'b0;
      end
      reset_n = 1'b1;
      for (int k = 1; k <= LAT + 2; k++)
         sb.push_back(mk({1'b1, k >= LAT ? 1'b0 : 1'b1}, k >= LAT ? 10'h2A5 : 10'h000,
                         {1'b0, evt(k)}, 2'b00));
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         e = sb.pop_front(); obs = {key_out, sw_out, key_press, key_release}; total++;
         if (obs !== e) begin bad++; $display("FAIL reset_mid_after s%0d got=%h exp=%h", k, obs, e); end
      end
      settle_idle();
   endtask

   initial begin
      reset_n   = 1'b0;
      key_in    = 2'b11;
      sw_in     = 10'h000;
      evt_clear = 2'b00;
      test_reset();
      test_glitch();
      test_press();
      test_simultaneous();
      test_switches();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
